// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder with valid/ready operand and result handshakes
// One full-adder slice per cycle, LSB first; the result is held until the consumer takes it.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;

  assign s_bit = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_bit = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)    state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = HOLD;
      HOLD:    if (out_ready)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operands shift right so bit k sits at [0] in cycle k; sum fills from the top and
  // ends with bit k at position k after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum_q <= {s_bit, sum_q[WIDTH-1:1]};
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) cout_q <= c_bit;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
// Expected results come from plain (WIDTH+1)-bit arithmetic on the operands.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Issues one add from IDLE and waits for out_valid; leaves the DUT in HOLD.
  task automatic start_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, output int lat);
    a = x; b = y; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== '0) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, required 1 0 0 00 0",
               in_ready, out_valid, busy, sum, cout);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [3] = '{8'h3C, 8'hFF, 8'hFF};
    logic [W-1:0] tb [3] = '{8'h0F, 8'h01, 8'hFF};
    logic         tc [3] = '{1'b0, 1'b1, 1'b1};
    logic [W:0]   req [3] = '{9'h04B, 9'h101, 9'h1FF};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_add(ta[i], tb[i], tc[i], lat);
      n_cmp++;
      if (lat !== W) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, required %0d", i, lat, W);
      end
      n_cmp++;
      if ({cout, sum} !== req[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, {cout, sum}, req[i]);
      end
      release_result();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || {cout, sum} !== req[i]) begin
        n_err++;
        $display("FAIL directed_idle[%0d]: in_ready=%b out_valid=%b result=%h, required 1 0 %h",
                 i, in_ready, out_valid, {cout, sum}, req[i]);
      end
    end
  endtask

  task automatic test_truth_table();
    int lat;
    for (int i = 0; i < 8; i++) begin
      logic xa, xb, xc;
      int total;
      xa = i[0]; xb = i[1]; xc = i[2];
      total = int'(xa) + int'(xb) + int'(xc);
      start_add({{(W-1){1'b0}}, xa}, {{(W-1){1'b0}}, xb}, xc, lat);
      n_cmp++;
      if (sum[1:0] !== total[1:0] || cout !== 1'b0) begin
        n_err++;
        $display("FAIL truth_table[%0d]: sum[1:0]=%b cout=%b, required %b 0", i, sum[1:0], cout, total[1:0]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W:0] exp_r;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    exp_r = model(a, b, cin);
    start_add(a, b, cin, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp_r) begin
        n_err++;
        $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b busy=%b result=%h, required 1 0 0 %h",
                 i, out_valid, in_ready, busy, {cout, sum}, exp_r);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {cout, sum} !== exp_r) begin
      n_err++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b result=%h, required 1 0 %h",
               in_ready, out_valid, {cout, sum}, exp_r);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a = 8'hA5; b = 8'h7E; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL run_busy: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    tick(); tick(); tick();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, busy, out_valid, cout} !== 4'b1000 || sum !== '0) begin
      n_err++;
      $display("FAIL reset_mid_run: in_ready=%b busy=%b out_valid=%b sum=%h cout=%b, required 1 0 0 00 0",
               in_ready, busy, out_valid, sum, cout);
    end
    tick(); tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    start_add(8'h01, 8'h02, 1'b0, lat);
    n_cmp++;
    if (lat !== W || {cout, sum} !== 9'h003) begin
      n_err++;
      $display("FAIL post_reset_add: latency=%0d result=%h, required %0d 003", lat, {cout, sum}, W);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [W:0] pend [$];
    int results = 0;
    int last_acc = -1;
    int cyc = 0;
    bit acc;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    while (results < 5 && cyc < 40 * W) begin
      acc = 1'b0;
      if (out_valid) begin
        n_cmp++;
        if (pend.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected: result %h with nothing outstanding", {cout, sum});
        end else begin
          logic [W:0] e;
          e = pend.pop_front();
          if ({cout, sum} !== e) begin
            n_err++;
            $display("FAIL b2b_result[%0d]: got %h, required %h", results, {cout, sum}, e);
          end
        end
        results++;
      end
      if (in_ready) begin
        acc = 1'b1;
        pend.push_back(model(a, b, cin));
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc !== W + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles, required %0d", cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
      end
      tick();
      cyc++;
      if (acc) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    n_cmp++;
    if (results !== 5) begin
      n_err++;
      $display("FAIL b2b_timeout: got %0d results, required 5", results);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    logic [W:0] exp_r;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      exp_r = model(a, b, cin);
      start_add(a, b, cin, lat);
      n_cmp++;
      if (lat !== W || {cout, sum} !== exp_r) begin
        n_err++;
        $display("FAIL random[%0d]: latency=%0d result=%h, required %0d %h", i, lat, {cout, sum}, W, exp_r);
      end
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_truth_table();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port a  input  WIDTH  first operand.
REQ-007 SHALL have port b  input  WIDTH  second operand.
REQ-008 SHALL have port cin  input  1  initial carry-in.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  WIDTH  registered sum.
REQ-012 SHALL have port cout  output  1  registered final carry-out.
REQ-013 SHALL have port busy  output  1  high while a serial add is in progress.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, HOLD; one-hot or binary encoding is implementation choice.
REQ-015 SHALL assert in_ready only in IDLE; accept transfer when in_valid && in_ready on a clock edge.
REQ-016 SHALL on accept capture a, b into shift registers, cin into carry flop, clear bit counter to 0, go to RUN.
REQ-017 SHALL in RUN use exactly one 1-bit full-adder slice per cycle: s = a[k]^b[k]^c, c' = majority(a[k], b[k], c), k = counter, LSB first.
REQ-018 SHALL shift s into sum register at bit position k and update carry flop with c' each RUN cycle.
REQ-019 SHALL increment counter each RUN cycle; after the cycle processing k = WIDTH-1 go to HOLD with cout = final carry.
REQ-020 SHALL have latency: out_valid rises exactly WIDTH cycles after the accept edge.
REQ-021 SHALL hold out_valid, sum, cout stable in HOLD until out_ready is sampled high; then go to IDLE.
REQ-022 SHALL assert busy iff state is RUN.
REQ-023 SHALL NOT accept new operands in RUN or HOLD; in_valid there is ignored and must not alter any state.
REQ-024 SHALL produce {cout, sum} = a + b + cin exactly (no truncation; WIDTH+1-bit result).
REQ-025 SHALL treat out_ready asserted in the same cycle out_valid first rises as a completed transfer (IDLE on next edge).
REQ-026 SHALL NOT combinationally forward in_valid to out_valid; minimum accept-to-next-accept spacing is WIDTH+2 cycles.
REQ-027 SHALL keep sum and cout at the last result values while in IDLE (not cleared on transfer).

Reset
REQ-028 SHALL on rst high at a clock edge enter IDLE regardless of current state, including mid-RUN.
REQ-029 SHALL reset outputs: in_ready=1 (after reset edge), out_valid=0, busy=0, sum=0, cout=0, counter=0, carry flop=0.
REQ-030 SHALL discard any partially computed result on reset; no out_valid for the aborted operation.
REQ-031 SHALL give rst priority over in_valid/out_ready sampled on the same edge.

Verification
REQ-032 SHALL verify WIDTH=8: a=0x3C, b=0x0F, cin=0 accepted -> out_valid exactly 8 cycles later, sum=0x4B, cout=0.
REQ-033 SHALL verify overflow: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 SHALL verify backpressure: out_ready low 5 cycles after out_valid -> sum/cout/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-035 SHALL verify reset mid-RUN: rst at cycle 4 of an add -> next cycle in_ready=1, busy=0, out_valid=0, sum=0, cout=0; subsequent a=0x01, b=0x02, cin=0 -> sum=0x03.
REQ-036 SHALL verify back-to-back: in_valid held high with out_ready held high -> accepts spaced WIDTH+2 cycles, every result matches a+b+cin.
REQ-037 SHALL verify all 8 single-bit combinations of (a[0], b[0], cin) with upper bits 0 against the full-adder truth table on sum[0], sum[1].
